// File: rtl/inst_fetch_unit_pkg.sv
// Shared CPU constants, opcode map and the fetch buffer entry layout.
// Every pipeline stage imports this package.
package inst_fetch_unit_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned INST_BYTES = 4;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

   localparam logic [6:0] OP_R       = 7'b0110011;
   localparam logic [6:0] OP_I       = 7'b0010011;
   localparam logic [6:0] OP_L       = 7'b0000011;
   localparam logic [6:0] OP_S       = 7'b0100011;
   localparam logic [6:0] OP_B       = 7'b1100011;
   localparam logic [6:0] OP_J       = 7'b1101111;
   localparam logic [6:0] OP_I_JALR  = 7'b1100111;
   localparam logic [6:0] OP_U_LUI   = 7'b0110111;
   localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_I_SYS   = 7'b1110011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

   // Sequential instruction address; wraps modulo 2^XLEN.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INST_BYTES);
   endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction memory request/response bus between fetch (master) and imem (slave).
interface inst_fetch_unit_if;
   import inst_fetch_unit_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid, imem_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

   modport slave (
      input  imem_req_valid, imem_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

endinterface

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries; flush beats push and pop.
module inst_fetch_unit_fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_c,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full_c,
   output logic                   empty_c
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign count   = count_q;
   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == '0);
   assign head_c  = mem_q[rd_ptr_q];

   // Pointer and occupancy update
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && !flush;
      do_pop   = pop && !empty_c && !flush;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: credit-limited imem requests, in-order response buffering
// with PC tagging, and redirect handling that squashes wrong-path responses.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   inst_fetch_unit_if.master  imem,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [XLEN-1:0]    inst,
   output logic [XLEN-1:0]    inst_pc
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0] fifo_count;
   logic [XLEN-1:0]  redirect_pc_aligned;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic             req_fire, rsp_fire, credit_ok;
   fetch_entry_t     push_entry, head_entry;

   // Registered counts only: every in-flight word must already have a FIFO slot.
   assign credit_ok = (SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);

   assign imem.imem_req_valid = rst_n && !redirect_valid && credit_ok;
   assign imem.imem_addr      = fetch_pc_q;

   assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
   assign rsp_fire            = imem.imem_rsp_valid;
   assign redirect_pc_aligned = redirect_pc & ~XLEN'(INST_BYTES - 1);
   assign push_entry          = '{pc: rsp_pc_q, inst: imem.imem_rsp_data};
   assign fifo_pop            = inst_valid && inst_ready;

   assign inst_valid = !fifo_empty;
   assign inst       = head_entry.inst;
   assign inst_pc    = head_entry.pc;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      fifo_push     = 1'b0;
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_d    = redirect_pc_aligned;
         rsp_pc_d      = redirect_pc_aligned;
         outstanding_d = outstanding_q - CNT_W'(rsp_fire);
         drop_cnt_d    = outstanding_q - CNT_W'(rsp_fire);
      end else begin
         if (req_fire) begin
            fetch_pc_d = next_pc(fetch_pc_q);
         end
         outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
         if (rsp_fire) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end else begin
               fifo_push = 1'b1;
               rsp_pc_d  = next_pc(rsp_pc_q);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   inst_fetch_unit_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .head_c    (head_entry),
      .count     (fifo_count),
      .full_c    (fifo_full),
      .empty_c   (fifo_empty)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a fixed-latency in-order imem model.
module tb_inst_fetch_unit;
   import inst_fetch_unit_pkg::*;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } pend_t;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int          n_cmp;
   int          n_mis;
   int          cyc;
   int          lat;
   int          wait_n;

   pend_t       pend[$];
   logic [31:0] req_log[$];
   int          req_cyc[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_inst[$];
   int          got_cyc[$];

   inst_fetch_unit_if bus ();

   inst_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (bus),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns ~addr after lat cycles; decode side logs every accepted pop.
   always begin
      @(posedge clk);
      if (!rst_n) begin
         pend.delete();
      end else begin
         if (bus.imem_rsp_valid) void'(pend.pop_front());
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back('{due: cyc + lat, addr: bus.imem_addr});
            req_log.push_back(bus.imem_addr);
            req_cyc.push_back(cyc);
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            got_pc.push_back(inst_pc);
            got_inst.push_back(inst);
            got_cyc.push_back(cyc);
         end
      end
      cyc++;
      #1;
      if (rst_n && pend.size() > 0 && pend[0].due == cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = ~pend[0].addr;
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'h0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] req_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] pc_at(input int i);
      return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] inst_at(input int i);
      return (i < got_inst.size()) ? got_inst[i] : 32'hDEAD_BEEF;
   endfunction
   function automatic int rcyc_at(input int i);
      return (i < req_cyc.size()) ? req_cyc[i] : -1000;
   endfunction
   function automatic int gcyc_at(input int i);
      return (i < got_cyc.size()) ? got_cyc[i] : -1000;
   endfunction

   task automatic clear_logs();
      req_log.delete();
      req_cyc.delete();
      got_pc.delete();
      got_inst.delete();
      got_cyc.delete();
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_test(input int l, input logic rdy);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      lat            = l;
      inst_ready     = rdy;
      run(2);
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(negedge clk);
      redirect_valid = 1'b0;
      clear_logs();
   endtask

   task automatic check_reset_outputs(input string t);
      check_eq({t, "_req_valid"},  32'(bus.imem_req_valid), 32'h0);
      check_eq({t, "_imem_addr"},  bus.imem_addr,           32'h0000_0000);
      check_eq({t, "_inst_valid"}, 32'(inst_valid),         32'h0);
      check_eq({t, "_inst"},       inst,                    32'h0);
      check_eq({t, "_inst_pc"},    inst_pc,                 32'h0);
   endtask

   initial begin
      n_cmp              = 0;
      n_mis              = 0;
      cyc                = 0;
      lat                = 1;
      rst_n              = 1'b0;
      redirect_valid     = 1'b0;
      redirect_pc        = 32'h0;
      inst_ready         = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;

      // 1: reset values, then sequential fetch with L=1
      run(2);
      check_reset_outputs("t1_rst");
      rst_n = 1'b1;
      clear_logs();
      run(12);
      check_eq("t1_addr0", req_at(0), 32'h0000_0000);
      check_eq("t1_addr1", req_at(1), 32'h0000_0004);
      check_eq("t1_addr2", req_at(2), 32'h0000_0008);
      check_eq("t1_addr3", req_at(3), 32'h0000_000C);
      check_eq("t1_back2back", 32'(rcyc_at(1) - rcyc_at(0)), 32'd1);
      check_eq("t1_first_lat", 32'(gcyc_at(0) - rcyc_at(0)), 32'd2);
      check_eq("t1_pc0", pc_at(0), 32'h0000_0000);
      check_eq("t1_pc1", pc_at(1), 32'h0000_0004);
      check_eq("t1_pc3", pc_at(3), 32'h0000_000C);
      check_eq("t1_inst0", inst_at(0), 32'hFFFF_FFFF);
      check_eq("t1_inst3", inst_at(3), 32'hFFFF_FFF3);

      // 2: decode stalled -> credit exhausts after two requests, nothing lost
      start_test(1, 1'b0);
      run(10);
      check_eq("t2_nreq", 32'(req_log.size()), 32'd2);
      check_eq("t2_req_valid", 32'(bus.imem_req_valid), 32'h0);
      check_eq("t2_inst_valid", 32'(inst_valid), 32'h1);
      check_eq("t2_head_pc", inst_pc, 32'h0000_0000);
      check_eq("t2_head_inst", inst, 32'hFFFF_FFFF);
      inst_ready = 1'b1;
      run(8);
      check_eq("t2_pc0", pc_at(0), 32'h0000_0000);
      check_eq("t2_pc1", pc_at(1), 32'h0000_0004);
      check_eq("t2_pc2", pc_at(2), 32'h0000_0008);
      check_eq("t2_nogap", 32'(gcyc_at(1) - gcyc_at(0)), 32'd1);

      // 3: L=3, redirect with two requests in flight
      start_test(3, 1'b1);
      wait_n = 0;
      while (req_log.size() < 2 && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      check_eq("t3_two_inflight", 32'(req_log.size()), 32'd2);
      check_eq("t3_credit_stop", 32'(bus.imem_req_valid), 32'h0);
      redirect_to(32'h0000_0100);
      run(15);
      check_eq("t3_req0", req_at(0), 32'h0000_0100);
      check_eq("t3_pc0", pc_at(0), 32'h0000_0100);
      check_eq("t3_inst0", inst_at(0), 32'hFFFF_FEFF);
      check_eq("t3_pc1", pc_at(1), 32'h0000_0104);

      // 4: redirect coincident with a response and a pop
      start_test(1, 1'b1);
      wait_n = 0;
      while (!(bus.imem_rsp_valid && inst_valid) && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      check_eq("t4_setup", 32'(bus.imem_rsp_valid && inst_valid), 32'h1);
      redirect_to(32'h0000_0200);
      check_eq("t4_flushed", 32'(inst_valid), 32'h0);
      check_eq("t4_addr", bus.imem_addr, 32'h0000_0200);
      run(8);
      check_eq("t4_req0", req_at(0), 32'h0000_0200);
      check_eq("t4_pc0", pc_at(0), 32'h0000_0200);
      check_eq("t4_inst0", inst_at(0), 32'hFFFF_FDFF);

      // 5: address wrap and alignment of redirect_pc
      start_test(1, 1'b1);
      run(3);
      redirect_to(32'hFFFF_FFF8);
      run(10);
      check_eq("t5_req0", req_at(0), 32'hFFFF_FFF8);
      check_eq("t5_req1", req_at(1), 32'hFFFF_FFFC);
      check_eq("t5_req2", req_at(2), 32'h0000_0000);
      check_eq("t5_pc1", pc_at(1), 32'hFFFF_FFFC);
      check_eq("t5_pc2", pc_at(2), 32'h0000_0000);
      check_eq("t5_inst2", inst_at(2), 32'hFFFF_FFFF);
      redirect_to(32'h0000_0102);
      check_eq("t5_align_addr", bus.imem_addr, 32'h0000_0100);
      run(8);
      check_eq("t5_align_req", req_at(0), 32'h0000_0100);
      check_eq("t5_align_pc", pc_at(0), 32'h0000_0100);

      // 6: reset mid-stream with a full buffer
      start_test(1, 1'b1);
      run(6);
      inst_ready = 1'b0;
      run(8);
      check_eq("t6_full_valid", 32'(inst_valid), 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("t6_rst");
      rst_n = 1'b1;
      inst_ready = 1'b1;
      clear_logs();
      run(8);
      check_eq("t6_req0", req_at(0), 32'h0000_0000);
      check_eq("t6_pc0", pc_at(0), 32'h0000_0000);
      check_eq("t6_inst0", inst_at(0), 32'hFFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
